// File: rtl/alarm_system_button_pio.sv
// Debounced button PIO with an Avalon-MM register interface.
// Each input bit is synchronized, debounced, then edge-detected. Captured
// edges are latched in edgecapture. The interrupt is driven either by the
// masked edge captures or by the masked debounced levels.
module alarm_system_button_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned IRQ_MODE        = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned CW = (DEBOUNCE_CYCLES <= 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_db_d;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_ec;

  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rd;

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

  generate
    if (WIDTH < 32) begin : g_unused
      logic w_unused_wdata;
      assign w_unused_wdata = |writedata[31:WIDTH];
    end
  endgenerate

  // Two-flop synchronizer on the asynchronous button inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce: a bit flips only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_db[i]  <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Edge detection on the debounced data.
  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = r_db & ~r_db_d;
      1:       w_edge = ~r_db & r_db_d;
      default: w_edge = r_db ^ r_db_d;
    endcase
  end

  // Delayed debounced data, interrupt mask and edge capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_d <= '0;
      r_mask <= '0;
      r_ec   <= '0;
    end else begin
      r_db_d <= r_db;
      if (w_wr && (address == 2'd2)) r_mask <= writedata[WIDTH-1:0];
      // A new edge wins over a simultaneous clear of the same bit.
      r_ec <= (r_ec & ~w_clr) | w_edge;
    end
  end

  // Read mux, zero-extended above WIDTH.
  always_comb begin
    w_rd = '0;
    case (address)
      2'd0:    w_rd[WIDTH-1:0] = r_db;
      2'd2:    w_rd[WIDTH-1:0] = r_mask;
      2'd3:    w_rd[WIDTH-1:0] = r_ec;
      default: w_rd = '0;
    endcase
  end

  // Registered read data, updated every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rd;
  end

  // Interrupt source selection.
  always_comb begin
    if (IRQ_MODE == 1) irq = |(r_ec & r_mask);
    else               irq = |(r_db & r_mask);
  end

endmodule

// File: tb/tb_alarm_system_button_pio.sv
// Randomized bench for alarm_system_button_pio. Two instances share stimulus:
// u0 uses defaults (rising edge, edge irq), u1 uses any-edge with level irq.
module tb_alarm_system_button_pio;

  localparam int W = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alarm_system_button_pio u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  alarm_system_button_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .IRQ_MODE(0)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1)
  );

  // Reference model: input delayed by two samples, a level is accepted once the
  // last D delayed samples all disagree with the current debounced level.
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_dbd = '0;
  logic [W-1:0] m_mask = '0, m_ec0 = '0, m_ec1 = '0;
  logic [31:0]  m_rd0 = '0, m_rd1 = '0;
  logic [W-1:0] m_hist [D];

  initial for (int j = 0; j < D; j++) m_hist[j] = '0;

  function automatic logic [31:0] sel(input logic [1:0] a, input logic [W-1:0] db,
                                      input logic [W-1:0] mk, input logic [W-1:0] ec);
    case (a)
      2'd0:    return {28'd0, db};
      2'd2:    return {28'd0, mk};
      2'd3:    return {28'd0, ec};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= '0; m_s2 <= '0; m_db <= '0; m_dbd <= '0;
      m_mask <= '0; m_ec0 <= '0; m_ec1 <= '0; m_rd0 <= '0; m_rd1 <= '0;
      for (int j = 0; j < D; j++) m_hist[j] <= '0;
    end else begin
      automatic logic [W-1:0] ndb = m_db;
      automatic logic [W-1:0] clr = '0;
      automatic bit wr = chipselect && !write_n;
      for (int b = 0; b < W; b++) begin
        automatic bit all_opp = 1'b1;
        for (int j = 0; j < D; j++) begin
          automatic logic v = (j == 0) ? m_s2[b] : m_hist[j-1][b];
          if (v == m_db[b]) all_opp = 1'b0;
        end
        if (all_opp) ndb[b] = ~m_db[b];
      end
      if (wr && address == 2'd3) clr = writedata[W-1:0];
      m_ec0 <= (m_ec0 & ~clr) | (m_db & ~m_dbd);
      m_ec1 <= (m_ec1 & ~clr) | (m_db ^ m_dbd);
      if (wr && address == 2'd2) m_mask <= writedata[W-1:0];
      m_rd0 <= sel(address, m_db, m_mask, m_ec0);
      m_rd1 <= sel(address, m_db, m_mask, m_ec1);
      m_hist[0] <= m_s2;
      for (int j = 1; j < D; j++) m_hist[j] <= m_hist[j-1];
      m_dbd <= m_db;
      m_db  <= ndb;
      m_s2  <= m_s1;
      m_s1  <= in_port;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd0", rd0, m_rd0);
      chk("rd1", rd1, m_rd1);
      chk("irq0", {31'd0, irq0}, {31'd0, |(m_ec0 & m_mask)});
      chk("irq1", {31'd0, irq1}, {31'd0, |(m_db & m_mask)});
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    cyc();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd_at(input logic [1:0] a);
    address = a;
    cyc();
  endtask

  initial begin
    reset_n = 1'b0;
    address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; in_port = '0;
    cyc(3);
    chk_en = 1'b1;
    chk("reset rd0", rd0, 32'd0);
    chk("reset irq0", {31'd0, irq0}, 32'd0);
    reset_n = 1'b1;
    cyc(2);

    // Held press on bit 0 with mask=1.
    bus_wr(2'd2, 32'd1);
    in_port = 4'b0001;
    cyc(8);
    rd_at(2'd3);
    chk("ec bit0 set", rd0, 32'd1);
    chk("irq edge", {31'd0, irq0}, 32'd1);
    bus_wr(2'd3, 32'hF);
    cyc();
    chk("irq cleared", {31'd0, irq0}, 32'd0);

    // Three-cycle glitch on bit 1 must be filtered.
    in_port = 4'b0011;
    cyc(3);
    in_port = 4'b0001;
    cyc(10);
    rd_at(2'd0);
    chk("glitch db", rd0, 32'd1);
    rd_at(2'd3);
    chk("glitch ec", rd0, 32'd0);

    // Upper writedata bits are dropped; writes to address 0 are ignored.
    bus_wr(2'd2, 32'hFFFF_FFF5);
    rd_at(2'd2);
    chk("mask read", rd0, 32'h0000_0005);
    bus_wr(2'd0, 32'hF);
    rd_at(2'd0);
    chk("db after wr0", rd0, 32'd1);

    // Reset mid-debounce, then exact re-debounce latency.
    in_port = 4'b1000;
    cyc(4);
    reset_n = 1'b0;
    cyc();
    chk("midreset rd0", rd0, 32'd0);
    chk("midreset irq0", {31'd0, irq0}, 32'd0);
    chk("midreset irq1", {31'd0, irq1}, 32'd0);
    address = 2'd0;
    reset_n = 1'b1;
    cyc(6);
    chk("db3 not yet", rd0, 32'd0);
    cyc();
    chk("db3 at 6", rd0, 32'd8);

    // Any-edge / level-irq instance on bit 2.
    bus_wr(2'd2, 32'd4);
    in_port = 4'b0100;
    cyc(8);
    chk("lvl irq on", {31'd0, irq1}, 32'd1);
    rd_at(2'd3);
    chk("ec1 press", rd1 & 32'd4, 32'd4);
    bus_wr(2'd3, 32'hF);
    in_port = 4'b0000;
    cyc(8);
    chk("lvl irq off", {31'd0, irq1}, 32'd0);
    rd_at(2'd3);
    chk("ec1 release", rd1 & 32'd4, 32'd4);

    // Randomized traffic.
    begin
      int hold = 0;
      for (int n = 0; n < 3000; n++) begin
        if (hold == 0) begin
          in_port = W'($urandom);
          hold = $urandom_range(1, 10);
        end
        hold--;
        address    = 2'($urandom);
        chipselect = 1'($urandom);
        write_n    = ($urandom_range(0, 3) != 0);
        writedata  = $urandom;
        if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
        else reset_n = 1'b1;
        cyc();
      end
    end
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
